// File: rtl/md_unit.sv
// md_unit -- multiply/divide unit for the execute stage of the MIPS core.
//
// Runs mult, multu, div, divu, mthi and mtlo on the forwarded rs/rt operands
// and holds the architectural HI/LO pair. mult/div take a fixed number of
// busy cycles. The full result is computed when the op is accepted and parked
// in shadow registers. It is committed to HI/LO when the busy count expires.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous, active-low reset
//   mdEn     E-stage instruction is an MD op this cycle
//   mdOp     000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU,
//            101 MTHI, 110 MTLO, 111 none
//   mdA      forwarded rs value
//   mdB      forwarded rt value
//   dUsesMd  D-stage instruction touches the MD unit (incl. mfhi/mflo)
//   mdHI     architectural HI
//   mdLO     architectural LO
//   mdBusy   multi-cycle operation in flight
//   mdStall  stall request to the hazard unit
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mdEn,
    input  logic [2:0]  mdOp,
    input  logic [31:0] mdA,
    input  logic [31:0] mdB,
    input  logic        dUsesMd,
    output logic [31:0] mdHI,
    output logic [31:0] mdLO,
    output logic        mdBusy,
    output logic        mdStall
);

    localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 15) ? $clog2(MAX_CYCLES + 1) : 4;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       nHI;
    logic [31:0]       nLO;
    logic              go;
    logic [63:0]       res;

    function automatic logic [63:0] mul_signed(input logic signed [31:0] a,
                                               input logic signed [31:0] b);
        logic signed [63:0] ea;
        logic signed [63:0] eb;
        ea = 64'(a);
        eb = 64'(b);
        return ea * eb;
    endfunction

    function automatic logic [63:0] mul_unsigned(input logic [31:0] a,
                                                 input logic [31:0] b);
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Signed divide done on magnitudes so that 0x80000000 / -1 yields
    // 0x80000000 without overflow. The quotient truncates toward zero and
    // the remainder takes the dividend's sign. Returns {remainder, quotient}.
    function automatic logic [63:0] div_signed(input logic signed [31:0] a,
                                               input logic signed [31:0] b);
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] q;
        logic [31:0] r;
        ma = a[31] ? 32'(-a) : 32'(a);
        mb = b[31] ? 32'(-b) : 32'(b);
        q  = ma / mb;
        r  = ma % mb;
        if (a[31] ^ b[31]) q = -q;
        if (a[31])         r = -r;
        return {r, q};
    endfunction

    function automatic logic [63:0] div_unsigned(input logic [31:0] a,
                                                 input logic [31:0] b);
        return {a % b, a / b};
    endfunction

    assign go      = mdEn && (state == IDLE) && (mdOp >= OP_MULT) && (mdOp <= OP_DIVU);
    assign mdBusy  = (state == BUSY);
    assign mdStall = dUsesMd && (mdBusy || go);

    // Result selection. A divide by zero re-loads the current HI/LO, so the
    // later commit leaves the architectural pair unchanged.
    always_comb begin
        res = {mdHI, mdLO};
        case (mdOp)
            OP_MULT:  res = mul_signed(mdA, mdB);
            OP_MULTU: res = mul_unsigned(mdA, mdB);
            OP_DIV:   if (mdB != 32'd0) res = div_signed(mdA, mdB);
            OP_DIVU:  if (mdB != 32'd0) res = div_unsigned(mdA, mdB);
            default:  res = {mdHI, mdLO};
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            nHI   <= '0;
            nLO   <= '0;
            mdHI  <= '0;
            mdLO  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        nHI   <= res[63:32];
                        nLO   <= res[31:0];
                        cnt   <= (mdOp == OP_MULT || mdOp == OP_MULTU) ?
                                 CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        state <= BUSY;
                    end else if (mdEn && mdOp == OP_MTHI) begin
                        mdHI <= mdA;
                    end else if (mdEn && mdOp == OP_MTLO) begin
                        mdLO <= mdA;
                    end
                end
                BUSY: begin
                    // Any MD op presented here is ignored.
                    if (cnt == CNT_W'(1)) begin
                        mdHI  <= nHI;
                        mdLO  <= nLO;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mdEn;
    logic [2:0]  mdOp;
    logic [31:0] mdA;
    logic [31:0] mdB;
    logic        dUsesMd;
    logic [31:0] mdHI;
    logic [31:0] mdLO;
    logic        mdBusy;
    logic        mdStall;

    always #5 clk = ~clk;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .mdEn    (mdEn),
        .mdOp    (mdOp),
        .mdA     (mdA),
        .mdB     (mdB),
        .dUsesMd (dUsesMd),
        .mdHI    (mdHI),
        .mdLO    (mdLO),
        .mdBusy  (mdBusy),
        .mdStall (mdStall)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_hi = 32'd0;
    logic [31:0] ref_lo = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: architectural effect of one op from the ISA rules.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] h, output logic [31:0] l);
        longint      sa, sb, q, r;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        h  = ref_hi;
        l  = ref_lo;
        case (op)
            3'd1: begin u = 64'(sa * sb); h = u[63:32]; l = u[31:0]; end
            3'd2: begin u = {32'b0, a} * {32'b0, b}; h = u[63:32]; l = u[31:0]; end
            3'd3: if (b != 0) begin q = sa / sb; r = sa % sb; h = r[31:0]; l = q[31:0]; end
            3'd4: if (b != 0) begin l = a / b; h = a % b; end
            3'd5: h = a;
            3'd6: l = a;
            default: ;
        endcase
    endtask

    // Scoreboard monitor: every busy->idle transition is a commit and pops one entry.
    initial begin
        bit   prev;
        int   bc;
        exp_t e;
        prev = 0;
        bc   = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                sbq.delete();
                prev = 0;
                bc   = 0;
            end else begin
                if (mdBusy) begin
                    bc++;
                end else if (prev) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_commit: got commit HI=%h LO=%h expected none", mdHI, mdLO);
                    end else begin
                        e = sbq.pop_front();
                        check("commit_hi", mdHI, e.hi);
                        check("commit_lo", mdLO, e.lo);
                        check("busy_len", 32'(bc), 32'(e.cyc));
                    end
                    bc = 0;
                end
                prev = mdBusy;
            end
        end
    end

    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic d);
        logic [31:0] h, l;
        int          n;
        mdEn = 1'b1; mdOp = op; mdA = a; mdB = b; dUsesMd = d;
        #1;
        if (d) check("stall_start", {31'b0, mdStall}, 32'd1);
        model(op, a, b, h, l);
        n = (op <= 3'd2) ? 5 : 10;
        sbq.push_back('{h, l, n});
        ref_hi = h;
        ref_lo = l;
        tick();
        mdEn = 1'b0; mdOp = 3'd0;
    endtask

    task automatic wait_done(input logic d);
        int k;
        for (k = 0; k < 40 && mdBusy; k++) begin
            if (d) check("stall_busy", {31'b0, mdStall}, 32'd1);
            tick();
        end
        if (mdBusy) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: got mdBusy=1 expected 0 within 40 cycles");
        end else begin
            if (d) check("stall_commit", {31'b0, mdStall}, 32'd0);
            check("hi_after", mdHI, ref_hi);
            check("lo_after", mdLO, ref_lo);
        end
    endtask

    task automatic mt_op(input logic [2:0] op, input logic [31:0] a);
        logic [31:0] h, l;
        mdEn = 1'b1; mdOp = op; mdA = a; mdB = $urandom; dUsesMd = 1'b0;
        model(op, a, 32'd0, h, l);
        ref_hi = h;
        ref_lo = l;
        tick();
        mdEn = 1'b0; mdOp = 3'd0;
        check("mt_busy", {31'b0, mdBusy}, 32'd0);
        check("mt_hi", mdHI, ref_hi);
        check("mt_lo", mdLO, ref_lo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        logic        d;
        reset = 1'b0; mdEn = 1'b0; mdOp = 3'd0; mdA = 32'd0; mdB = 32'd0; dUsesMd = 1'b0;
        repeat (3) tick();
        check("rst_hi", mdHI, 32'd0);
        check("rst_lo", mdLO, 32'd0);
        check("rst_busy", {31'b0, mdBusy}, 32'd0);
        reset = 1'b1;
        repeat (2) tick();
        check("post_rst_hi", mdHI, 32'd0);
        check("post_rst_lo", mdLO, 32'd0);
        check("post_rst_busy", {31'b0, mdBusy}, 32'd0);

        // Directed operations from the ISA examples
        start_op(3'd1, 32'hFFFFFFFE, 32'd3, 1'b1);
        wait_done(1'b1);
        check("mult_hi", mdHI, 32'hFFFFFFFF);
        check("mult_lo", mdLO, 32'hFFFFFFFA);
        start_op(3'd2, 32'hFFFFFFFE, 32'd3, 1'b0);
        wait_done(1'b0);
        check("multu_hi", mdHI, 32'h00000002);
        check("multu_lo", mdLO, 32'hFFFFFFFA);
        start_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b1);
        wait_done(1'b1);
        check("div_hi", mdHI, 32'hFFFFFFFF);
        check("div_lo", mdLO, 32'hFFFFFFFD);
        start_op(3'd4, 32'd7, 32'd2, 1'b0);
        wait_done(1'b0);
        check("divu_hi", mdHI, 32'd1);
        check("divu_lo", mdLO, 32'd3);
        mt_op(3'd5, 32'h12345678);
        mt_op(3'd6, 32'h00000000);
        start_op(3'd3, 32'h55AA55AA, 32'd0, 1'b1);
        wait_done(1'b1);
        check("div0_hi", mdHI, 32'h12345678);
        check("div0_lo", mdLO, 32'h00000000);
        start_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        wait_done(1'b0);
        check("ovf_hi", mdHI, 32'h00000000);
        check("ovf_lo", mdLO, 32'h80000000);

        // Ops presented mid-busy must be ignored
        start_op(3'd1, 32'hFFFFFFFE, 32'd3, 1'b1);
        tick();
        mdEn = 1'b1; mdOp = 3'd1; mdA = 32'h00001234; mdB = 32'h00005678; dUsesMd = 1'b1;
        #1;
        check("stall_ignored", {31'b0, mdStall}, 32'd1);
        tick();
        mdOp = 3'd5; mdA = 32'hDEADBEEF;
        tick();
        mdOp = 3'd6; mdA = 32'hCAFEF00D;
        tick();
        mdEn = 1'b0; mdOp = 3'd0;
        wait_done(1'b1);
        check("ignored_hi", mdHI, 32'hFFFFFFFF);
        check("ignored_lo", mdLO, 32'hFFFFFFFA);

        // Reset asserted during busy cycle 3 of a DIV
        start_op(3'd3, 32'd100, 32'd7, 1'b0);
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        check("abort_busy", {31'b0, mdBusy}, 32'd0);
        check("abort_hi", mdHI, 32'd0);
        check("abort_lo", mdLO, 32'd0);
        ref_hi = 32'd0;
        ref_lo = 32'd0;
        tick();
        tick();
        reset = 1'b1;
        repeat (15) tick();
        check("no_commit_busy", {31'b0, mdBusy}, 32'd0);
        check("no_commit_hi", mdHI, 32'd0);
        check("no_commit_lo", mdLO, 32'd0);

        // Randomised mix against the reference model
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(1, 6));
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2:       b = 32'($urandom_range(1, 16));
                3:       b = -32'($urandom_range(1, 16));
                default: b = $urandom;
            endcase
            d = 1'($urandom_range(0, 1));
            if (op <= 3'd4) begin
                start_op(op, a, b, d);
                wait_done(d);
            end else begin
                mt_op(op, a);
            end
        end

        dUsesMd = 1'b0;
        repeat (2) tick();
        check("queue_drained", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
